// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD-to-binary serial decoder.
// Holds the default digit count, the FSM state type and the digit validity check.
package bcd_pkg;

    localparam int DEF_DIGITS = 2;
    localparam int BCD_W      = 4 * DEF_DIGITS + 1;

    // Widest operand the validity helper accepts; narrower operands are zero-extended.
    localparam int MAX_DIGITS = 8;
    localparam int BCD_MAX_W  = 4 * MAX_DIGITS + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic bcd_digits_valid(
        input logic [BCD_MAX_W-1:0] bcd,
        input int                   ndigits = DEF_DIGITS
    );
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < ndigits && bcd[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_nibble_adjust.sv
// Reverse double-dabble correction for one BCD nibble after a right shift.
// A nibble of 8 or more picked up a carried-in 8 that is really worth 5.
module bcd_nibble_adjust (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd8) ? (nib_i - 4'd3) : nib_i;

endmodule

// File: rtl/bcd_to_binary_serial.sv
// Serial BCD-to-binary decoder: one shift-and-correct step per clock.
// Accepts {carry, digits} on start and pulses done when bin_out/err are valid.
module bcd_to_binary_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int BIN_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [4*DIGITS:0]  bcd_in,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [BIN_W-1:0]   bin_out
);

    localparam int NIB   = DIGITS + 1;
    localparam int SR_W  = 4 * NIB + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_e             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [BIN_W-1:0]   bin_q, bin_d;

    logic [SR_W-1:0]    sr_shift;
    logic [SR_W-1:0]    sr_step;
    logic [4*NIB-1:0]   nib_adj;
    logic               in_valid;
    logic               last_step;

    // Shift first, then correct every BCD nibble of the shifted value.
    assign sr_shift = sr_q >> 1;

    for (genvar g = 0; g < NIB; g++) begin : g_adj
        bcd_nibble_adjust u_adj (
            .nib_i (sr_shift[BIN_W + 4*g +: 4]),
            .nib_o (nib_adj[4*g +: 4])
        );
    end

    assign sr_step   = {nib_adj, sr_shift[BIN_W-1:0]};
    assign in_valid  = bcd_digits_valid(BCD_MAX_W'(bcd_in), DIGITS);
    assign last_step = (cnt_q == CNT_W'(BIN_W - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = in_valid ? CONV : DONE;
            CONV:    if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        err_d = err_q;
        bin_d = bin_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (in_valid) begin
                        sr_d  = {3'b000, bcd_in, {BIN_W{1'b0}}};
                        cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                        bin_d = '0;
                    end
                end
            end
            CONV: begin
                sr_d  = sr_step;
                cnt_d = cnt_q + CNT_W'(1);
                // Result is taken from the value produced by the final step.
                if (last_step) begin
                    bin_d = sr_step[BIN_W-1:0];
                    err_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            bin_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            bin_q <= bin_d;
        end
    end

    assign err     = err_q;
    assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_binary_serial.sv
// Self-checking bench for bcd_to_binary_serial against a decimal-arithmetic model.
module tb_bcd_to_binary_serial;

    localparam int DIGITS = 2;
    localparam int BIN_W  = 8;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [8:0]       bcd_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [BIN_W-1:0] bin_out;

    int vectors     = 0;
    int miscompares = 0;

    bcd_to_binary_serial #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Decimal meaning of a packed operand: carry*100 + tens*10 + ones.
    function automatic void model(input logic [8:0] b, output int val, output bit ok);
        int hund, tens, ones;
        hund = int'(b[8]);
        tens = int'(b[7:4]);
        ones = int'(b[3:0]);
        ok   = (tens <= 9) && (ones <= 9);
        val  = ok ? hund * 100 + tens * 10 + ones : 0;
    endfunction

    function automatic logic [8:0] to_bcd(input int v);
        logic [8:0] b;
        b[8]   = 1'(v / 100);
        b[7:4] = 4'((v / 10) % 10);
        b[3:0] = 4'(v % 10);
        return b;
    endfunction

    // Run one conversion; optionally pulse a second start (0x007) at a given edge count.
    task automatic do_conv(input logic [8:0] b, input string tag, input int inject_at = -1);
        int exp_val;
        bit ok;
        int edges;
        model(b, exp_val, ok);
        @(negedge clk);
        start  = 1'b1;
        bcd_in = b;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 9'($urandom);
        check({tag, " busy"}, 32'(busy), 32'd1);
        while (!done && edges < 40) begin
            if (edges == inject_at) begin
                start  = 1'b1;
                bcd_in = 9'h007;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(edges), ok ? 32'(1 + BIN_W) : 32'd1);
        check({tag, " bin_out"}, 32'(bin_out), 32'(exp_val));
        check({tag, " err"}, 32'(err), ok ? 32'd0 : 32'd1);
        @(negedge clk);
        check({tag, " done width"}, 32'(done), 32'd0);
        check({tag, " busy after"}, 32'(busy), 32'd0);
        check({tag, " hold"}, 32'(bin_out), 32'(exp_val));
    endtask

    initial begin
        logic [8:0] sweep [5];
        logic [8:0] r;
        sweep[0] = 9'h000; sweep[1] = 9'h009; sweep[2] = 9'h010;
        sweep[3] = 9'h099; sweep[4] = 9'h100;

        reset_n = 1'b0;
        start   = 1'b0;
        bcd_in  = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle busy", 32'(busy), 32'd0);
            check("idle done", 32'(done), 32'd0);
            check("idle err", 32'(err), 32'd0);
            check("idle bin_out", 32'(bin_out), 32'd0);
        end

        do_conv(9'h199, "max 199");
        foreach (sweep[i]) do_conv(sweep[i], $sformatf("sweep %03h", sweep[i]));

        do_conv(9'h0A5, "bad tens");
        do_conv(9'h042, "after bad");
        do_conv(9'h10F, "bad ones");
        do_conv(9'h150, "start ignored", 3);

        // Reset during step 4 of a conversion of 0x123.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 9'h123;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid-reset busy", 32'(busy), 32'd0);
        check("mid-reset done", 32'(done), 32'd0);
        check("mid-reset err", 32'(err), 32'd0);
        check("mid-reset bin_out", 32'(bin_out), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_conv(9'h055, "post reset");

        for (int v = 0; v < 200; v++) do_conv(to_bcd(v), $sformatf("exh %0d", v));

        for (int k = 0; k < 40; k++) begin
            r = 9'($urandom);
            do_conv(r, $sformatf("rand %03h", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
